// File: rtl/ui_debounce_if.sv
// ui_debounce_if: pad-side bus into and conditioned bus out of ui_debounce.
// DB_EVENT_COUNT_EN adds the evt_clr/evt_cnt pair.
interface ui_debounce_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             busy;
`ifdef DB_EVENT_COUNT_EN
  logic             evt_clr;
  logic [7:0]       evt_cnt;

  modport master (
    output ena, raw_in, evt_clr,
    input  db_out, rise, fall, busy, evt_cnt
  );
  modport slave (
    input  ena, raw_in, evt_clr,
    output db_out, rise, fall, busy, evt_cnt
  );
`else
  modport master (
    output ena, raw_in,
    input  db_out, rise, fall, busy
  );
  modport slave (
    input  ena, raw_in,
    output db_out, rise, fall, busy
  );
`endif
endinterface

// File: rtl/ui_debounce.sv
// ui_debounce: 2-FF sync plus per-bit stability counter, rise/fall pulses.
// Optional DB_EVENT_COUNT_EN adds an 8-bit accepted-rise event counter.
module ui_debounce #(
  parameter int WIDTH           = 8,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  ui_debounce_if.slave bus
);

  generate
    if (DEBOUNCE_CYCLES < 1 ||
        DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_cfg
      $error("ui_debounce: DEBOUNCE_CYCLES out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1;
  logic [WIDTH-1:0]            s2;
  logic [WIDTH-1:0]            db;
  logic [WIDTH-1:0]            rise;
  logic [WIDTH-1:0]            fall;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  logic [WIDTH-1:0]            db_n;
  logic [WIDTH-1:0]            rise_n;
  logic [WIDTH-1:0]            fall_n;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_n;
  logic                        busy;

  always_comb begin
    db_n   = db;
    rise_n = '0;
    fall_n = '0;
    cnt_n  = cnt;
    busy   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      busy = busy | (cnt[i] != '0);
      if (s2[i] == db[i]) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == LAST) begin
        cnt_n[i]  = '0;
        db_n[i]   = s2[i];
        rise_n[i] = s2[i];
        fall_n[i] = ~s2[i];
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      rise <= '0;
      fall <= '0;
      cnt  <= '0;
    end else if (bus.ena) begin
      s1   <= bus.raw_in;
      s2   <= s1;
      db   <= db_n;
      rise <= rise_n;
      fall <= fall_n;
      cnt  <= cnt_n;
    end else begin
      rise <= '0;
      fall <= '0;
    end
  end

  assign bus.db_out = db;
  assign bus.rise   = rise;
  assign bus.fall   = fall;
  assign bus.busy   = busy;

`ifdef DB_EVENT_COUNT_EN
  logic [7:0] evt;

  // Clear wins over increment and is honoured even while frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt <= '0;
    end else if (bus.evt_clr) begin
      evt <= '0;
    end else if (bus.ena && (|rise_n)) begin
      evt <= evt + 8'd1;
    end
  end

  assign bus.evt_cnt = evt;
`endif

endmodule
